// File: rtl/embedded_system_nios2_jtag_debug_host.sv
// embedded_system_nios2_jtag_debug_host: runs one virtual-JTAG UIR/CDR/SDR/UDR sequence per command
// with a divided TCK, shifting SR_W bits LSB first and returning the captured target data.
module embedded_system_nios2_jtag_debug_host #(
   parameter int TCK_DIV = 2,
   parameter int SR_W    = 38
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic [1:0]      cmd_ir,
   input  logic [SR_W-1:0] cmd_data,
   output logic            rsp_valid,
   output logic [SR_W-1:0] rsp_data,
   output logic [1:0]      rsp_ir_out,
   output logic            vji_tck,
   output logic            vji_tdi,
   input  logic            vji_tdo,
   output logic [1:0]      vji_ir_in,
   input  logic [1:0]      vji_ir_out,
   output logic            vji_uir,
   output logic            vji_cdr,
   output logic            vji_sdr,
   output logic            vji_udr,
   output logic            vji_rti
);
   typedef enum logic [2:0] {IDLE, UIR, CDR, SDR, UDR} state_t;
   localparam logic [8:0] RISE     = 9'(TCK_DIV - 1);
   localparam logic [8:0] HALF     = 9'(TCK_DIV);
   localparam logic [8:0] LAST     = 9'(2 * TCK_DIV - 1);
   localparam logic [5:0] BIT_LAST = 6'(SR_W - 1);
   state_t          state, state_nx;
   logic [8:0]      cnt, cnt_nx;
   logic [5:0]      bit_cnt;
   logic [SR_W-1:0] tx, rx;
   logic [1:0]      ir_cap;
   logic            rdy_q, tck_q, accept, period_end, tck_rise;

   always_comb begin
      cmd_ready  = (state == IDLE) && rdy_q;
      accept     = cmd_valid && cmd_ready;
      period_end = (state != IDLE) && (cnt == LAST);
      tck_rise   = (state != IDLE) && (cnt == RISE);
      cnt_nx     = ((state == IDLE) || period_end) ? 9'd0 : cnt + 9'd1;
      state_nx   = state;
      case (state)
         IDLE:    state_nx = accept ? UIR : IDLE;
         UIR:     state_nx = period_end ? CDR : UIR;
         CDR:     state_nx = period_end ? SDR : CDR;
         SDR:     state_nx = (period_end && bit_cnt == BIT_LAST) ? UDR : SDR;
         UDR:     state_nx = period_end ? IDLE : UDR;
         default: state_nx = IDLE;
      endcase
      vji_tck = tck_q;
      vji_rti = (state == IDLE);
      vji_uir = (state == UIR);
      vji_cdr = (state == CDR);
      vji_sdr = (state == SDR);
      vji_udr = (state == UDR);
      vji_tdi = (state == SDR) ? tx[0] : 1'b0;
   end

   // tck is registered from the next-cycle counter so the target sees a glitch-free clock
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         bit_cnt    <= '0;
         tx         <= '0;
         rx         <= '0;
         ir_cap     <= '0;
         rdy_q      <= 1'b0;
         tck_q      <= 1'b0;
         vji_ir_in  <= '0;
         rsp_valid  <= 1'b0;
         rsp_data   <= '0;
         rsp_ir_out <= '0;
      end else begin
         rdy_q     <= 1'b1;
         state     <= state_nx;
         cnt       <= cnt_nx;
         tck_q     <= (state_nx != IDLE) && (cnt_nx >= HALF);
         rsp_valid <= (state == UDR) && period_end;
         if (accept) begin
            vji_ir_in <= cmd_ir;
            tx        <= cmd_data;
            bit_cnt   <= '0;
         end
         if (state == SDR && period_end) begin
            tx      <= tx >> 1;
            bit_cnt <= (bit_cnt == BIT_LAST) ? bit_cnt : bit_cnt + 6'd1;
         end
         if (tck_rise && state == CDR) ir_cap <= vji_ir_out;
         if (tck_rise && state == SDR) rx <= {vji_tdo, rx[SR_W-1:1]};
         if (state == UDR && period_end) begin
            rsp_data   <= rx;
            rsp_ir_out <= ir_cap;
         end
      end
   end
endmodule

// File: tb/tb_embedded_system_nios2_jtag_debug_host.sv
// tb_embedded_system_nios2_jtag_debug_host: directed vector table plus hand-written
// back-to-back, reset-abort and TCK_DIV=1 sequences against a small tdo target model.
module tb_embedded_system_nios2_jtag_debug_host;
   localparam int W = 38;
   logic clk = 1'b0, reset = 1'b1;
   always #5 clk = ~clk;

   logic         cv = 1'b0, cr, rv, tck, tdi, tdo, uir, cdr, sdr, udr, rti;
   logic [1:0]   ir = '0, rio, iri, iro;
   logic [W-1:0] cd = '0, rd;
   logic         cv1 = 1'b0, cr1, rv1, tck1, tdi1, uir1, cdr1, sdr1, udr1, rti1;
   logic [1:0]   ir1 = '0, rio1, iri1;
   logic [W-1:0] cd1 = '0, rd1;

   embedded_system_nios2_jtag_debug_host #(.TCK_DIV(2), .SR_W(W)) dut (
      .clk(clk), .reset(reset), .cmd_valid(cv), .cmd_ready(cr), .cmd_ir(ir), .cmd_data(cd),
      .rsp_valid(rv), .rsp_data(rd), .rsp_ir_out(rio), .vji_tck(tck), .vji_tdi(tdi),
      .vji_tdo(tdo), .vji_ir_in(iri), .vji_ir_out(iro), .vji_uir(uir), .vji_cdr(cdr),
      .vji_sdr(sdr), .vji_udr(udr), .vji_rti(rti));

   embedded_system_nios2_jtag_debug_host #(.TCK_DIV(1), .SR_W(W)) dut1 (
      .clk(clk), .reset(reset), .cmd_valid(cv1), .cmd_ready(cr1), .cmd_ir(ir1), .cmd_data(cd1),
      .rsp_valid(rv1), .rsp_data(rd1), .rsp_ir_out(rio1), .vji_tck(tck1), .vji_tdi(tdi1),
      .vji_tdo(tdi1), .vji_ir_in(iri1), .vji_ir_out(2'b11), .vji_uir(uir1), .vji_cdr(cdr1),
      .vji_sdr(sdr1), .vji_udr(udr1), .vji_rti(rti1));

   // target model: pattern source or one-period-delayed loopback, plus tdi capture
   logic         mode = 1'b0, lb = 1'b0;
   logic [W-1:0] pat = '0, cap = '0;
   int           idx = 0;
   assign iro = cdr ? 2'b10 : 2'b01;
   assign tdo = mode ? lb : (idx < W ? pat[idx] : 1'b0);
   always @(posedge tck) begin
      lb <= tdi;
      if (cdr) idx <= 0;
      else if (sdr) idx <= idx + 1;
      if (sdr) cap <= {tdi, cap[W-1:1]};
   end

   int errors = 0, checks = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic run2(input string nm, input logic [1:0] cir, input logic [W-1:0] cdat,
                       input logic [W-1:0] exp);
      int n, nu, nc, ns, nd, nt;
      @(negedge clk);
      chk({nm, "_ready"}, 64'(cr), 64'd1);
      cv = 1'b1; ir = cir; cd = cdat;
      @(negedge clk);
      cv = 1'b0; n = 1; nu = 0; nc = 0; ns = 0; nd = 0; nt = 0;
      chk({nm, "_ir_in"}, 64'(iri), 64'(cir));
      while (!rv && n < 400) begin
         nu += int'(uir); nc += int'(cdr); ns += int'(sdr); nd += int'(udr); nt += int'(tck);
         @(negedge clk);
         n++;
      end
      chk({nm, "_latency"}, 64'(n), 64'd165);
      chk({nm, "_rsp_data"}, 64'(rd), 64'(exp));
      chk({nm, "_tdi_cap"}, 64'(cap), 64'(cdat));
      chk({nm, "_rsp_ir_out"}, 64'(rio), 64'd2);
      chk({nm, "_state_cycles"}, {16'(nu), 16'(nc), 16'(ns), 16'(nd)}, {16'd4, 16'd4, 16'd152, 16'd4});
      chk({nm, "_tck_high"}, 64'(nt), 64'd82);
      @(negedge clk);
      chk({nm, "_pulse_hold"}, {62'(rv), 38'(rd)}, {62'd0, 38'(exp)});
   endtask

   typedef struct {
      string        nm;
      logic [1:0]   ir;
      logic [W-1:0] data;
      logic         mode;
      logic [W-1:0] pat;
      logic [W-1:0] exp;
   } vec_t;
   vec_t v[4];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, bad, tog, hi;
      logic prev;
      v[0] = '{"pat_dead",  2'b01, 38'h2A_5555_AAAA, 1'b0, 38'h15_DEAD_BEEF, 38'h15_DEAD_BEEF};
      v[1] = '{"loop_ones", 2'b10, 38'h3F_FFFF_FFFF, 1'b1, 38'h0,            38'h3F_FFFF_FFFE};
      v[2] = '{"loop_one",  2'b11, 38'h00_0000_0001, 1'b1, 38'h0,            38'h00_0000_0002};
      v[3] = '{"pat_1234",  2'b00, 38'h25_A5A5_5A5A, 1'b0, 38'h0A_1234_5678, 38'h0A_1234_5678};

      @(negedge clk);
      chk("reset_outs", 64'({cr, rti, tck, tdi, uir, cdr, sdr, udr, rv, iri, rio}), 64'h800);
      chk("reset_data", 64'(rd), 64'd0);
      reset = 1'b0;
      @(negedge clk);
      chk("ready_after_reset", 64'({cr, rti}), 64'd3);

      for (int i = 0; i < 4; i++) begin
         mode = v[i].mode; pat = v[i].pat;
         run2(v[i].nm, v[i].ir, v[i].data, v[i].exp);
      end

      // second command held valid throughout the first must wait for the rsp_valid cycle
      mode = 1'b0; pat = 38'h15_DEAD_BEEF;
      @(negedge clk);
      cv = 1'b1; ir = 2'b01; cd = 38'h2A_5555_AAAA;
      @(negedge clk);
      ir = 2'b10; cd = 38'h3F_FFFF_FFFF; n = 1; bad = 0;
      while (!rv && n < 400) begin
         if (iri !== 2'b01) bad++;
         @(negedge clk);
         n++;
      end
      chk("b2b_first_latency", 64'(n), 64'd165);
      chk("b2b_ignored", 64'(bad), 64'd0);
      chk("b2b_ready_at_rsp", 64'(cr), 64'd1);
      chk("b2b_first_data", 64'(rd), 64'h15_DEAD_BEEF);
      @(negedge clk);
      cv = 1'b0;
      chk("b2b_second_start", 64'({uir, iri}), 64'({1'b1, 2'b10}));
      n = 1;
      while (!rv && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk("b2b_second_latency", 64'(n), 64'd165);
      chk("b2b_second_cap", 64'(cap), 64'h3F_FFFF_FFFF);

      // TCK_DIV=1 instance with immediate loopback
      @(negedge clk);
      cv1 = 1'b1; ir1 = 2'b11; cd1 = 38'h15_0F0F_F0F0;
      @(negedge clk);
      cv1 = 1'b0; n = 1; tog = 0; hi = 0; prev = tck1;
      while (!rv1 && n < 200) begin
         hi += int'(tck1);
         if (n > 1 && tck1 !== prev) tog++;
         prev = tck1;
         @(negedge clk);
         n++;
      end
      chk("div1_latency", 64'(n), 64'd83);
      chk("div1_tck", {32'(hi), 32'(tog)}, {32'd41, 32'd81});
      chk("div1_rsp", 64'({rio1, rd1}), 64'({2'b11, 38'h15_0F0F_F0F0}));

      // asynchronous reset in SDR bit 20 aborts the command
      mode = 1'b0; pat = 38'h0A_1234_5678;
      @(negedge clk);
      cv = 1'b1; ir = 2'b10; cd = 38'h11_2233_4455;
      @(negedge clk);
      cv = 1'b0;
      repeat (88) @(negedge clk);
      chk("abort_in_sdr", 64'(sdr), 64'd1);
      reset = 1'b1;
      #1;
      chk("abort_outs", 64'({cr, rti, tck, tdi, uir, cdr, sdr, udr, rv, iri, rio}), 64'h800);
      chk("abort_data", 64'(rd), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      bad = 0;
      repeat (200) begin
         @(negedge clk);
         if (rv !== 1'b0) bad++;
      end
      chk("abort_no_rsp", 64'(bad), 64'd0);
      run2("after_abort", 2'b01, 38'h2A_5555_AAAA, 38'h0A_1234_5678);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/embedded_system_nios2_jtag_debug_host.md
EMBEDDED_SYSTEM_NIOS2_JTAG_DEBUG_HOST -- requirements
Module: embedded_system_nios2_jtag_debug_host

Interface
REQ-001 Parameter TCK_DIV, default 2: clk cycles per vji_tck half-period; legal range 1..255.
REQ-002 Parameter SR_W, default 38: data-register shift length in bits.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 cmd_valid  input  1  command present.
REQ-006 cmd_ready  output  1  block accepts a command this cycle.
REQ-007 cmd_ir  input  2  virtual IR value to apply.
REQ-008 cmd_data  input  SR_W  data to shift into target, LSB first.
REQ-009 rsp_valid  output  1  one-cycle pulse: shift complete.
REQ-010 rsp_data  output  SR_W  bits shifted out of target; held until next completion.
REQ-011 rsp_ir_out  output  2  vji_ir_out sampled during the CDR period; held until next completion.
REQ-012 vji_tck  output  1  generated test clock to debug-module TCK side.
REQ-013 vji_tdi  output  1  serial data to target.
REQ-014 vji_tdo  input  1  serial data from target.
REQ-015 vji_ir_in  output  2  virtual IR to target.
REQ-016 vji_ir_out  input  2  status from target.
REQ-017 vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti  output  1 each  virtual JTAG state strobes.

Function
REQ-018 FSM states IDLE, UIR, CDR, SDR, UDR; each non-IDLE state occupies whole TCK periods of 2*TCK_DIV clk cycles.
REQ-019 IDLE: vji_tck=0, vji_rti=1, all other strobes 0, cmd_ready=1; all other states: cmd_ready=0, vji_rti=0.
REQ-020 Handshake: command accepted in cycle with cmd_valid&cmd_ready; cmd_valid while cmd_ready=0 is ignored, no buffering.
REQ-021 On acceptance: vji_ir_in<=cmd_ir, tx<=cmd_data, bit counter<=0, state<=UIR next cycle; vji_ir_in holds until next acceptance.
REQ-022 vji_tck: low for first TCK_DIV cycles of each period, high for last TCK_DIV cycles; state and strobe changes occur only at period start (tck low).
REQ-023 Strobes one-hot and equal to current state: vji_uir in UIR, vji_cdr in CDR, vji_sdr in SDR, vji_udr in UDR.
REQ-024 Transitions: UIR->CDR after 1 period; CDR->SDR after 1 period; SDR->UDR after SR_W periods; UDR->IDLE after 1 period.
REQ-025 rsp_ir_out sampled on vji_tck rising edge during CDR.
REQ-026 SDR: vji_tdi=tx[0] stable for whole period; tx shifts right by 1 at each period end.
REQ-027 SDR: on each vji_tck rising edge rx<={vji_tdo, rx[SR_W-1:1]}; after SR_W bits, rx[0] is first bit received.
REQ-028 vji_tdi=0 outside SDR.
REQ-029 In first IDLE cycle after UDR: rsp_data<=rx and rsp_valid=1 for exactly one cycle; cmd_ready=1 in same cycle, back-to-back acceptance legal.
REQ-030 Latency accept->rsp_valid: 1+(SR_W+3)*2*TCK_DIV clk cycles (TCK_DIV=2, SR_W=38: 165).
REQ-031 Bit counter 6 bits wide, saturates at SR_W-1; no wrap.

Reset
REQ-032 While reset=1, immediately: state=IDLE, vji_tck=0, vji_rti=1, vji_tdi=0, vji_ir_in=0, all strobes 0, rsp_valid=0, rsp_data=0, rsp_ir_out=0, cmd_ready=0.
REQ-033 First rising clk edge after reset deasserts: cmd_ready=1.
REQ-034 Reset mid-command aborts it: no rsp_valid, rsp_data cleared, vji_tck low within reset assertion.

Verification
REQ-035 Single command, TCK_DIV=2: cmd_ir=2'b01, cmd_data=38'h2A_5555_AAAA, tdo model returns sequence 38'h15_DEAD_BEEF LSB first -> UIR/CDR 4 cycles each, 38 sdr periods, rsp_valid at accept+165, rsp_data=38'h15_DEAD_BEEF, captured tdi=38'h2A_5555_AAAA.
REQ-036 Loopback vji_tdo=vji_tdi delayed one tck period: cmd_data=38'h3F_FFFF_FFFF -> rsp_data=38'h3F_FFFF_FFFE.
REQ-037 Back-to-back: second cmd_valid held during first -> ignored until rsp_valid cycle, accepted there; second UIR starts next cycle, vji_ir_in updates to new value.
REQ-038 TCK_DIV=1: vji_tck toggles every clk in non-IDLE; rsp_valid at accept+83.
REQ-039 Reset asserted during SDR bit 20 -> outputs at reset values same cycle (asynchronous), no rsp_valid; next command completes normally.
REQ-040 vji_ir_out=2'b10 during CDR, 2'b01 elsewhere -> rsp_ir_out=2'b10.
